// File: rtl/segment_timer.sv
// segment_timer: measures ticks between entry and exit sensor rises and holds the result
// until the consumer acknowledges it.
module segment_timer #(
    parameter int CLK_DIV   = 50000,
    parameter int MAX_COUNT = 32767
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        sensor_a,
    input  logic        sensor_b,
    input  logic        time_ack,
    output logic [14:0] time_out,
    output logic        time_valid,
    output logic        busy,
    output logic        overflow
);
    localparam int PW = $clog2(CLK_DIV);
    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] COUNT  = 2'd1;
    localparam logic [1:0] REPORT = 2'd2;

    logic [1:0]    r_a_sync, r_b_sync, r_state;
    logic          r_a_q, r_b_q, r_valid, r_ovf;
    logic [PW-1:0] r_presc;
    logic [14:0]   r_count, r_time;
    logic          w_a_rise, w_b_rise;

    assign w_a_rise   = r_a_sync[1] & ~r_a_q;
    assign w_b_rise   = r_b_sync[1] & ~r_b_q;
    assign time_out   = r_time;
    assign time_valid = r_valid;
    assign busy       = (r_state == COUNT);
    assign overflow   = r_ovf;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a_sync <= '0;
            r_b_sync <= '0;
            r_a_q    <= 1'b0;
            r_b_q    <= 1'b0;
        end else begin
            r_a_sync <= {r_a_sync[0], sensor_a};
            r_b_sync <= {r_b_sync[0], sensor_b};
            r_a_q    <= r_a_sync[1];
            r_b_q    <= r_b_sync[1];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_presc <= '0;
            r_count <= '0;
            r_time  <= '0;
            r_valid <= 1'b0;
            r_ovf   <= 1'b0;
        end else begin
            case (r_state)
                IDLE: if (w_a_rise) begin
                    r_state <= COUNT;
                    r_presc <= '0;
                    r_count <= '0;
                    r_ovf   <= 1'b0;
                end
                COUNT: if (w_b_rise) begin
                    r_time  <= r_count;
                    r_valid <= 1'b1;
                    r_state <= REPORT;
                end else if (w_a_rise) begin
                    r_presc <= '0;
                    r_count <= '0;
                    r_ovf   <= 1'b0;
                end else if (r_presc == PW'(CLK_DIV - 1)) begin
                    r_presc <= '0;
                    // a tick arriving at saturation is recorded as overflow, count holds
                    if (r_count == 15'(MAX_COUNT)) r_ovf <= 1'b1;
                    else r_count <= r_count + 15'd1;
                end else begin
                    r_presc <= r_presc + 1'b1;
                end
                REPORT: if (time_ack) begin
                    r_valid <= 1'b0;
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_segment_timer.sv
// tb_segment_timer: table-driven measurements on CLK_DIV=4 and CLK_DIV=2 instances sharing
// sensors; expected results are queued at the exit-sensor rise and popped on time_valid.
`timescale 1ns/1ps
module tb_segment_timer;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        sensor_a = 1'b0;
    logic        sensor_b = 1'b0;
    logic        time_ack = 1'b0;
    logic [14:0] t4, t2;
    logic        v4, v2, b4, b2, o4, o2;
    logic        p4 = 1'b0, p2 = 1'b0;
    int          n_checks = 0;
    int          n_errors = 0;

    typedef struct { logic [14:0] t; logic o; } exp_t;
    typedef struct {
        int          restart;
        int          d;
        int          held;
        logic [14:0] e4;
        logic        x4;
        logic [14:0] e2;
        logic        x2;
    } vec_t;

    exp_t q4[$];
    exp_t q2[$];
    vec_t vecs[7];

    always #5 clk = ~clk;

    segment_timer #(.CLK_DIV(4)) u4 (
        .clk(clk), .rst_n(rst_n), .sensor_a(sensor_a), .sensor_b(sensor_b),
        .time_ack(time_ack), .time_out(t4), .time_valid(v4), .busy(b4), .overflow(o4)
    );
    segment_timer #(.CLK_DIV(2)) u2 (
        .clk(clk), .rst_n(rst_n), .sensor_a(sensor_a), .sensor_b(sensor_b),
        .time_ack(time_ack), .time_out(t2), .time_valid(v2), .busy(b2), .overflow(o2)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [14:0] e4, input logic x4, input logic [14:0] e2, input logic x2);
        exp_t e;
        e.t = e4; e.o = x4; q4.push_back(e);
        e.t = e2; e.o = x2; q2.push_back(e);
    endtask

    task automatic wait_valid(input int lim);
        for (int i = 0; i < lim && !(v4 && v2); i++) tick(1);
        chk("valid4 rise", {31'd0, v4}, 1);
        chk("valid2 rise", {31'd0, v2}, 1);
    endtask

    task automatic ack_pulse();
        time_ack = 1'b1;
        tick(1);
        time_ack = 1'b0;
        chk("valid4 after ack", {31'd0, v4}, 0);
        chk("valid2 after ack", {31'd0, v2}, 0);
        chk("busy4 after ack", {31'd0, b4}, 0);
    endtask

    task automatic run_vec(input vec_t v);
        sensor_a = 1'b1;
        for (int c = 1; c <= v.restart; c++) begin
            tick(1);
            if (c == 3) sensor_a = 1'b0;
            if (c == v.restart) sensor_a = 1'b1;
        end
        for (int c = 1; c <= v.d; c++) begin
            tick(1);
            if (c == 3 && v.held == 0) sensor_a = 1'b0;
        end
        if (v.d >= 4) chk("busy4 counting", {31'd0, b4}, 1);
        push(v.e4, v.x4, v.e2, v.x2);
        sensor_b = 1'b1;
        tick(3);
        sensor_a = 1'b0;
        sensor_b = 1'b0;
        wait_valid(10);
        tick(20);
        chk("valid4 held", {31'd0, v4}, 1);
        chk("time2 held", {17'd0, t2}, {17'd0, v.e2});
        ack_pulse();
        tick(2);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (v4 && !p4) begin
            if (q4.size() == 0) chk("unexpected valid4", 1, 0);
            else begin
                e = q4.pop_front();
                chk("time4", {17'd0, t4}, {17'd0, e.t});
                chk("ovf4", {31'd0, o4}, {31'd0, e.o});
            end
        end
        if (v2 && !p2) begin
            if (q2.size() == 0) chk("unexpected valid2", 1, 0);
            else begin
                e = q2.pop_front();
                chk("time2", {17'd0, t2}, {17'd0, e.t});
                chk("ovf2", {31'd0, o2}, {31'd0, e.o});
            end
        end
        p4 <= v4;
        p2 <= v2;
    end

    initial begin
        vecs[0] = '{0, 65537, 0, 15'd16384, 1'b0, 15'd32767, 1'b1};
        vecs[1] = '{0, 9,     0, 15'd2,     1'b0, 15'd4,     1'b0};
        vecs[2] = '{100, 41,  0, 15'd10,    1'b0, 15'd20,    1'b0};
        vecs[3] = '{0, 1001,  1, 15'd250,   1'b0, 15'd500,   1'b0};
        vecs[4] = '{0, 2,     0, 15'd0,     1'b0, 15'd0,     1'b0};
        vecs[5] = '{0, 5,     0, 15'd1,     1'b0, 15'd2,     1'b0};
        vecs[6] = '{0, 4,     0, 15'd0,     1'b0, 15'd1,     1'b0};

        tick(2);
        chk("rst time4", {17'd0, t4}, 0);
        chk("rst valid4", {31'd0, v4}, 0);
        chk("rst busy4", {31'd0, b4}, 0);
        chk("rst ovf2", {31'd0, o2}, 0);
        rst_n = 1'b1;
        tick(2);

        run_vec(vecs[0]);

        // async reset mid-measurement, between clock edges
        sensor_a = 1'b1;
        tick(3);
        sensor_a = 1'b0;
        tick(50);
        chk("busy4 before reset", {31'd0, b4}, 1);
        #3 rst_n = 1'b0;
        #1;
        chk("async busy4", {31'd0, b4}, 0);
        chk("async time4", {17'd0, t4}, 0);
        chk("async ovf2", {31'd0, o2}, 0);
        tick(2);
        rst_n = 1'b1;
        tick(1);
        sensor_b = 1'b1;
        tick(20);
        chk("no valid after reset", {31'd0, v4 | v2}, 0);
        sensor_b = 1'b0;
        tick(5);
        sensor_b = 1'b1;
        tick(10);
        chk("b in idle busy4", {31'd0, b4}, 0);
        chk("b in idle valid2", {31'd0, v2}, 0);
        sensor_b = 1'b0;
        tick(5);

        for (int i = 1; i < 7; i++) run_vec(vecs[i]);

        // simultaneous rise in IDLE starts counting, b ignored
        sensor_a = 1'b1;
        sensor_b = 1'b1;
        for (int c = 1; c <= 20; c++) begin
            tick(1);
            if (c == 3) begin sensor_a = 1'b0; sensor_b = 1'b0; end
            if (c == 6) begin
                chk("simul idle busy2", {31'd0, b2}, 1);
                chk("simul idle valid4", {31'd0, v4}, 0);
            end
        end
        push(15'd4, 1'b0, 15'd9, 1'b0);
        sensor_b = 1'b1;
        tick(3);
        sensor_b = 1'b0;
        wait_valid(10);
        ack_pulse();
        tick(2);

        // simultaneous rise in COUNT reports, then REPORT ignores sensors
        sensor_a = 1'b1;
        for (int c = 1; c <= 30; c++) begin
            tick(1);
            if (c == 3) sensor_a = 1'b0;
        end
        push(15'd7, 1'b0, 15'd14, 1'b0);
        sensor_a = 1'b1;
        sensor_b = 1'b1;
        tick(3);
        sensor_a = 1'b0;
        sensor_b = 1'b0;
        wait_valid(10);
        tick(3);
        sensor_a = 1'b1;
        sensor_b = 1'b1;
        tick(6);
        sensor_a = 1'b0;
        sensor_b = 1'b0;
        tick(4);
        chk("report hold time4", {17'd0, t4}, 7);
        chk("report hold time2", {17'd0, t2}, 14);
        chk("report hold valid4", {31'd0, v4}, 1);
        chk("report busy4", {31'd0, b4}, 0);

        // ack held high: valid lasts exactly one cycle
        time_ack = 1'b1;
        tick(1);
        chk("held ack valid4", {31'd0, v4}, 0);
        tick(5);
        sensor_a = 1'b1;
        for (int c = 1; c <= 13; c++) begin
            tick(1);
            if (c == 3) sensor_a = 1'b0;
        end
        push(15'd3, 1'b0, 15'd6, 1'b0);
        sensor_b = 1'b1;
        tick(3);
        sensor_b = 1'b0;
        wait_valid(10);
        tick(1);
        chk("one-cycle valid4", {31'd0, v4}, 0);
        chk("one-cycle valid2", {31'd0, v2}, 0);
        time_ack = 1'b0;
        tick(3);

        chk("q4 drained", q4.size(), 0);
        chk("q2 drained", q2.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/segment_timer.md
# segment_timer

Measures the travel time of a train across one track segment: counts time ticks from the rising edge of the entry sensor to the rising edge of the exit sensor. It produces the 15-bit measured time consumed by the Predictor's `time_in` port, so it is the producer end of that interface. The result is held with a valid/ack handshake until the consumer accepts it.

## Interface

Parameters:
- `CLK_DIV`, default 50000: clock cycles per time tick (1 ms at 50 MHz); must be ≥ 2.
- `MAX_COUNT`, default 32767: saturation value of the tick counter (fits 15 bits).

Ports:
- `clk`  in  1  single system clock, rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `sensor_a`  in  1  entry sensor, asynchronous level, active-high.
- `sensor_b`  in  1  exit sensor, asynchronous level, active-high.
- `time_ack`  in  1  consumer accepts `time_out`.
- `time_out`  out  15  measured ticks (Predictor `time_in` format).
- `time_valid`  out  1  `time_out` holds a completed measurement.
- `busy`  out  1  measurement in progress.
- `overflow`  out  1  counter saturated during the current or last measurement.

## Operation

- **Input conditioning**
  - Each sensor passes through a 2-flop synchronizer, then an edge register.
  - `a_rise` / `b_rise` is a one-cycle pulse on a 0→1 transition of the synchronized level.
  - A sensor held high produces exactly one pulse.
- **FSM states:** IDLE, COUNT, REPORT.
- **IDLE**
  - `a_rise` → COUNT: `prescaler <= 0`, `count <= 0`, `overflow <= 0`.
  - `b_rise` is ignored.
  - If `a_rise` and `b_rise` arrive together, start counting and ignore `b_rise`.
- **COUNT**, on an edge without `b_rise`:
  - If `prescaler == CLK_DIV-1`: `prescaler <= 0` and `count` increments.
  - Otherwise `prescaler` increments.
  - `count` saturates at `MAX_COUNT`. The increment attempt at saturation sets `overflow`, which stays set.
- **COUNT** with `b_rise` (wins over a simultaneous `a_rise`):
  - `time_out <= count`, `time_valid <= 1` → REPORT.
- **COUNT** with `a_rise` only: restart. `prescaler`, `count` and `overflow` clear; the state stays COUNT.
- **REPORT**
  - `time_valid` and `time_out` hold.
  - `time_ack` sampled high → `time_valid <= 0` → IDLE.
  - Sensor pulses are ignored; a train entering before ack is not measured.
- **Outputs**
  - `busy` = (state == COUNT).
  - `overflow` stays visible through REPORT and clears on the next start.
- **Result arithmetic:** for rise-pulse separation D clocks (`b_rise` edge minus `a_rise` edge), `time_out` = min(floor((D−1)/CLK_DIV), `MAX_COUNT`).
- **Widths:** `prescaler` is sized by clog2(`CLK_DIV`); `count` is 15 bits.

## Timing

- **Reset:** `rst_n` low clears everything asynchronously: state = IDLE, `time_out` = 0, `time_valid` = 0, `busy` = 0, `overflow` = 0, prescaler and synchronizer flops = 0.
- **Reset mid-measurement:** the measurement is discarded, with no valid pulse.
- **Sensor latency:** the pin rising edge reaches the rise pulse 2–3 clocks later. Both sensors have equal latency, so it cancels in D.
- **Result latency:** `time_valid` rises on the same edge that samples `b_rise`.
- **Handshake**
  - `time_valid` falls on the edge after `time_ack` is sampled high.
  - Ack while `time_valid` = 0 has no effect.
  - Ack held high continuously drops `time_valid` after exactly one cycle.
- **Next measurement:** the earliest possible start is one cycle after returning to IDLE.

## Test plan

- **Nominal:** `CLK_DIV` = 4; `sensor_a` rise, then `sensor_b` rise 60005 clocks later → `time_out` = 15001, `time_valid` = 1, `overflow` = 0. `time_ack` one cycle → `time_valid` = 0 next cycle, `busy` = 0.
- **Reset values and async reset:** check all reset values. Assert `rst_n` low mid-COUNT without a clock edge → outputs clear immediately; a later `sensor_b` rise gives no `time_valid`.
- **Saturation:** `CLK_DIV` = 2; D = 70000 → `time_out` = 32767, `overflow` = 1. The next measurement with D = 9 gives `time_out` = 4, `overflow` = 0.
- **Restart:** second `sensor_a` rise 100 clocks into COUNT, then `sensor_b` 41 clocks after the second `a` (`CLK_DIV` = 4) → `time_out` = 10.
- **Ignored events:**
  - `sensor_b` rise in IDLE → no state change.
  - `sensor_a`/`sensor_b` rises during REPORT → `time_out` unchanged.
  - Simultaneous `a`/`b` rise in IDLE → enters COUNT.
  - Simultaneous `a`/`b` rise in COUNT → result reported.
- **Level-held sensors:** `sensor_a` held high for 1000 clocks, then `sensor_b` → exactly one start and one result; `time_valid` is held indefinitely until `time_ack`.
